// File: rtl/fnd_scan_ctrl_if.sv
// Bundles the data, control and display signals of the 4-digit FND scan controller.
// Clock and reset stay as plain ports on the module.
interface fnd_scan_ctrl_if;
  logic [13:0] i_value;
  logic        i_load;
  logic        i_blank_lz;
  logic [1:0]  o_digit_sel;
  logic [3:0]  o_bcd;
  logic        o_blank;
  logic        o_busy;
  logic        o_done;
  logic        o_ovf;

  modport master (
    output i_value, i_load, i_blank_lz,
    input  o_digit_sel, o_bcd, o_blank, o_busy, o_done, o_ovf
  );

  modport slave (
    input  i_value, i_load, i_blank_lz,
    output o_digit_sel, o_bcd, o_blank, o_busy, o_done, o_ovf
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Four-digit seven-segment scan controller: converts a saturated 14-bit binary value
// to BCD by serial double-dabble and multiplexes the digits at a CLK_DIV-cycle step.
module fnd_scan_ctrl #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  fnd_scan_ctrl_if.slave bus
);

  localparam int unsigned PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PS_TERM = PW'(CLK_DIV - 1);
  localparam logic [13:0] MAX_VAL   = 14'd9999;
  localparam logic [3:0]  LAST_BIT  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_UPDATE
  } state_t;

  state_t        state, state_nxt;
  logic          capture, shift, commit;

  logic [13:0]   bin_q;
  logic [15:0]   bcd_q;
  logic [3:0]    bit_cnt;
  logic          ovf_cap;
  logic [29:0]   dd_word;

  logic [PW-1:0] presc;
  logic [1:0]    sel, sel_nxt;
  logic [3:0]    disp     [4];
  logic [3:0]    disp_nxt [4];
  logic [3:0]    zero_from;
  logic          blank_nxt;
  logic [3:0]    bcd_nxt;
  logic          ovf_q, done_q, blank_q;
  logic [3:0]    bcd_out_q;

  // Add-3 correction applied to every BCD nibble before each shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    capture   = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_load) begin
          capture   = 1'b1;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        shift = 1'b1;
        if (bit_cnt == LAST_BIT) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- converter
  assign dd_word = {dd_adjust(bcd_q), bin_q};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      ovf_cap <= 1'b0;
    end else if (capture) begin
      bin_q   <= (bus.i_value > MAX_VAL) ? MAX_VAL : bus.i_value;
      ovf_cap <= (bus.i_value > MAX_VAL);
      bcd_q   <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      {bcd_q, bin_q} <= {dd_word[28:0], 1'b0};
      bit_cnt        <= bit_cnt + 4'd1;
    end
  end

  // ------------------------------------------------- display next state
  // Output digit is computed from next-cycle select and display values so that
  // the registered bcd/blank always match the registered digit select.
  assign sel_nxt = (presc == PS_TERM) ? sel + 2'd1 : sel;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      disp_nxt[k] = commit ? bcd_q[4*k +: 4] : disp[k];
    end
  end

  always_comb begin
    zero_from[3] = (disp_nxt[3] == 4'd0);
    zero_from[2] = zero_from[3] && (disp_nxt[2] == 4'd0);
    zero_from[1] = zero_from[2] && (disp_nxt[1] == 4'd0);
    zero_from[0] = zero_from[1] && (disp_nxt[0] == 4'd0);
  end

  assign blank_nxt = bus.i_blank_lz && (sel_nxt != 2'd0) && zero_from[sel_nxt];
  assign bcd_nxt   = blank_nxt ? 4'h0 : disp_nxt[sel_nxt];

  // ------------------------------------------------- scan and display
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc     <= '0;
      sel       <= 2'd0;
      bcd_out_q <= 4'h0;
      blank_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      // NOTE: the display array is reset explicitly; a post-reset display of 0000 depends on it.
      for (int k = 0; k < 4; k++) disp[k] <= 4'd0;
    end else begin
      presc     <= (presc == PS_TERM) ? '0 : presc + PW'(1);
      sel       <= sel_nxt;
      bcd_out_q <= bcd_nxt;
      blank_q   <= blank_nxt;
      done_q    <= commit;
      if (commit) ovf_q <= ovf_cap;
      for (int k = 0; k < 4; k++) disp[k] <= disp_nxt[k];
    end
  end

  assign bus.o_digit_sel = sel;
  assign bus.o_bcd       = bcd_out_q;
  assign bus.o_blank     = blank_q;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_done      = done_q;
  assign bus.o_ovf       = ovf_q;

endmodule
